uart_rx: RTL

- UART receive half of the full-duplex configurable UART; counterpart to Tx.
- Deserialises the asynchronous RxD line into bytes using an oversampling tick from a baud generator running at OVERSAMPLE × baud.
- Presents each received word with a one-cycle valid strobe and reports framing and parity errors.
- Sits beside Tx and shares clk/rst with it and with the baud generator.

---
 rtl/uart_rx.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronised RxD, oversampled mid-bit sampling, optional parity,
// one-cycle ready/parity/framing strobes and a break state that waits for the line to recover.
`timescale 1ns / 1ps

module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       os_tick,
  input  logic       RxD,
  output logic [7:0] RxD_data,
  output logic       RxD_data_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       Busy
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = 3;

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;
  localparam logic [2:0] BRK   = 3'd5;

  logic [1:0]           sync_q;
  logic                 rxs;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic [7:0]           data_q, data_d;
  logic                 ready_q, ready_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  assign rxs = sync_q[1];

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    data_d    = data_q;
    ready_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;

    case (state_q)
      IDLE: begin
        // Start detection is not tick-qualified so back-to-back frames are caught at once.
        if (!rxs) begin
          state_d   = START;
          tick_d    = '0;
          par_bad_d = 1'b0;
        end
      end
      START: begin
        if (os_tick) begin
          if (tick_q == TICK_MID) begin
            if (!rxs) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (os_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              state_d = (PARITY != 0) ? PAR : STOP;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      PAR: begin
        if (os_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d    = '0;
            par_bad_d = ((^shift_q) ^ rxs) != PAR_ODD;
            state_d   = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (os_tick) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (rxs) begin
              data_d  = 8'(shift_q);
              ready_d = 1'b1;
              perr_d  = par_bad_q;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BRK;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      BRK: begin
        // Hold here until the line recovers so a held-low line cannot retrigger a frame.
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], RxD};
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      data_q    <= data_d;
      ready_q   <= ready_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign RxD_data       = data_q;
  assign RxD_data_ready = ready_q;
  assign parity_err     = perr_q;
  assign frame_err      = ferr_q;
  assign Busy           = (state_q != IDLE);

endmodule
